// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with 3-sample majority vote, parity/frame flags, FWFT receive FIFO and sticky overrun; define UART_RX_BREAK_EN to suppress break frames and pulse break_det
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          data,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic                          break_det
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int W = DATA_BITS + 2;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4, PUSH = 3'd5;
  logic rx_s1, rx_s2, rx_q;
  logic [2:0] state;
  logic [DW-1:0] div_cnt;
  logic [OW-1:0] os_cnt;
  logic [3:0] bit_cnt;
  logic [1:0] samp;
  logic [DATA_BITS-1:0] shift;
  logic par_err_r, frm_err_r;
  logic tick, bit_end, vote, maj, last_stop;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [W-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop, full, wr_en;
`ifdef UART_RX_BREAK_EN
  localparam logic [2:0] WAIT_IDLE = 3'd6;
  logic all_zero, brk;
  assign brk = all_zero & ~maj;
`else
  assign break_det = 1'b0;
`endif
  assign tick = div_cnt == DW'(DIV - 1);
  assign bit_end = tick && os_cnt == OW'(OVERSAMPLE - 1);
  assign vote = tick && os_cnt == OW'(OVERSAMPLE / 2 + 1);
  assign maj = (samp[0] & samp[1]) | (samp[0] & rx_s2) | (samp[1] & rx_s2);
  assign last_stop = bit_cnt == 4'(STOP_BITS - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q <= 1'b1;
      state <= IDLE;
      div_cnt <= '0;
      os_cnt <= '0;
      bit_cnt <= '0;
      samp <= '0;
      shift <= '0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
`ifdef UART_RX_BREAK_EN
      all_zero <= 1'b1;
      break_det <= 1'b0;
`endif
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q <= rx_s2;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
      if (tick && os_cnt == OW'(OVERSAMPLE / 2 - 1)) samp[0] <= rx_s2;
      if (tick && os_cnt == OW'(OVERSAMPLE / 2)) samp[1] <= rx_s2;
`ifdef UART_RX_BREAK_EN
      break_det <= 1'b0;
      all_zero <= state == IDLE ? 1'b1 : vote ? brk : all_zero;
`endif
      case (state)
        IDLE: if (rx_q && !rx_s2) begin
          state <= START;
          div_cnt <= '0;
          os_cnt <= '0;
          bit_cnt <= '0;
          par_err_r <= 1'b0;
          frm_err_r <= 1'b0;
        end
        START: state <= vote && maj ? IDLE : bit_end ? DATA : START;
        DATA: begin
          if (vote) shift <= {maj, shift[DATA_BITS-1:1]};
          if (bit_end) bit_cnt <= bit_cnt == 4'(DATA_BITS - 1) ? '0 : bit_cnt + 1'b1;
          if (bit_end && bit_cnt == 4'(DATA_BITS - 1)) state <= PARITY != 0 ? PAR : STOP;
        end
        PAR: begin
          if (vote) par_err_r <= maj != ((^shift) ^ (PARITY == 2));
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (vote) frm_err_r <= frm_err_r | ~maj;
          if (bit_end) bit_cnt <= bit_cnt + 1'b1;
          if (vote && last_stop) begin
`ifdef UART_RX_BREAK_EN
            state <= brk ? WAIT_IDLE : PUSH;
            break_det <= brk;
`else
            state <= PUSH;
`endif
          end
        end
`ifdef UART_RX_BREAK_EN
        WAIT_IDLE: begin
          if (!rx_s2) div_cnt <= '0;
          if (!rx_s2) os_cnt <= '0;
          if (rx_s2 && bit_end) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
  assign push = state == PUSH;
  assign pop = data_valid & data_ready;
  assign full = count == CW'(FIFO_DEPTH);
  assign wr_en = push & (~full | pop);
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
      overrun <= (push & ~wr_en) | (overrun & ~overrun_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_ptr] <= {frm_err_r, par_err_r, shift};
  end
  assign data_valid = count != '0;
  assign level = count;
  assign head = data_valid ? mem[rd_ptr] : '0;
  assign {frame_err, parity_err, data} = head;
endmodule
